// File: rtl/urc_rover_pkg.sv
// Shared constants and FSM state type for the URC rover ADC acquisition path.
`timescale 1ns/1ps
package urc_rover_pkg;

  localparam int ADC_BITS    = 8;
  localparam int FRAME_BITS  = 16;
  localparam int LEAD_ZEROS  = 4;
  localparam int TRAIL_ZEROS = 4;

  typedef enum logic [2:0] {IDLE, START, SHIFT, DONE, QUIET} adc_state_t;

endpackage

// File: rtl/ad7478_ctrl.sv
// AD7478 frame sequencer: drives the shared CS/SCLK pair and captures one
// 16-bit frame per ADC.
`timescale 1ns/1ps
module ad7478_ctrl
  import urc_rover_pkg::*;
#(
  parameter int NUM_ADCS  = 1,
  parameter int QUIET_CYC = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_ADCS-1:0]          sdat,
  output logic                         cs,
  output logic                         mclk,
  output logic [ADC_BITS*NUM_ADCS-1:0] data,
  output logic                         valid,
  output logic [NUM_ADCS-1:0]          err
);

  localparam int QW = $clog2(QUIET_CYC + 1);

  adc_state_t            state, state_d;
  logic                  cs_d, mclk_d;
  logic [4:0]            bit_cnt;
  logic [QW-1:0]         quiet_cnt;
  logic [FRAME_BITS-1:0] sreg [NUM_ADCS];

  // CS/MCLK are computed from the next state so the pins change on the same
  // edge as the state register.
  always_comb begin
    state_d = state;
    cs_d    = 1'b1;
    mclk_d  = 1'b1;
    case (state)
      IDLE:    state_d = START;
      START:   state_d = SHIFT;
      SHIFT:   if (bit_cnt == 5'd31) state_d = DONE;
      DONE:    state_d = QUIET;
      QUIET:   if (quiet_cnt == QW'(QUIET_CYC - 1)) state_d = START;
      default: state_d = IDLE;
    endcase
    case (state_d)
      START: cs_d = 1'b0;
      SHIFT: begin
        cs_d   = 1'b0;
        mclk_d = (state == SHIFT) ? ~mclk : 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cs        <= 1'b1;
      mclk      <= 1'b1;
      valid     <= 1'b0;
      data      <= '0;
      err       <= '0;
      bit_cnt   <= '0;
      quiet_cnt <= '0;
      for (int i = 0; i < NUM_ADCS; i++) sreg[i] <= '0;
    end else begin
      state <= state_d;
      cs    <= cs_d;
      mclk  <= mclk_d;
      valid <= (state == DONE);
      case (state)
        START:   bit_cnt   <= '0;
        SHIFT:   bit_cnt   <= bit_cnt + 5'd1;
        DONE:    quiet_cnt <= '0;
        QUIET:   quiet_cnt <= quiet_cnt + QW'(1);
        default: ;
      endcase
      // Sample on the edge that drives MCLK low-to-high, i.e. the ADC's rising SCLK.
      if (state == SHIFT && !mclk) begin
        for (int i = 0; i < NUM_ADCS; i++)
          sreg[i] <= {sreg[i][FRAME_BITS-2:0], sdat[i]};
      end
      if (state == DONE) begin
        for (int i = 0; i < NUM_ADCS; i++) begin
          data[i*ADC_BITS +: ADC_BITS] <= sreg[i][TRAIL_ZEROS +: ADC_BITS];
          err[i] <= (sreg[i][FRAME_BITS-1 -: LEAD_ZEROS] != '0) ||
                    (sreg[i][TRAIL_ZEROS-1:0] != '0);
        end
      end
    end
  end

endmodule

// File: rtl/urc_rover.sv
// URC rover top level: OSCCLK-domain reset synchronizer plus the AD7478
// acquisition controller.
`timescale 1ns/1ps
module urc_rover
  import urc_rover_pkg::*;
#(
  parameter int NUM_ADCS  = 1,
  parameter int QUIET_CYC = 2
) (
  input  logic                         OSCCLK,
  input  logic                         EXTRST,
  output logic                         ADC_CS,
  output logic                         ADC_MCLK,
  input  logic [NUM_ADCS-1:0]          ADC_SDAT,
  output logic [ADC_BITS*NUM_ADCS-1:0] ADC_DATA,
  output logic                         ADC_VALID,
  output logic [NUM_ADCS-1:0]          ADC_ERR
);

  logic [1:0] rst_ff;
  logic       rst_sync;

  // Asserts immediately with EXTRST, releases two OSCCLK edges later.
  always_ff @(posedge OSCCLK or posedge EXTRST) begin
    if (EXTRST) rst_ff <= 2'b11;
    else        rst_ff <= {rst_ff[0], 1'b0};
  end

  assign rst_sync = rst_ff[1];

  ad7478_ctrl #(
    .NUM_ADCS  (NUM_ADCS),
    .QUIET_CYC (QUIET_CYC)
  ) u_ctrl (
    .clk   (OSCCLK),
    .rst   (rst_sync),
    .sdat  (ADC_SDAT),
    .cs    (ADC_CS),
    .mclk  (ADC_MCLK),
    .data  (ADC_DATA),
    .valid (ADC_VALID),
    .err   (ADC_ERR)
  );

endmodule

// File: tb/tb_urc_rover.sv
// Bench for urc_rover with two behavioural AD7478 models and a scoreboard of
// expected samples pushed at each CS fall.
`timescale 1ns/1ps
module tb_urc_rover;

  localparam int NUM_ADCS = 2;

  logic        OSCCLK   = 1'b0;
  logic        EXTRST   = 1'b1;
  logic        ADC_CS;
  logic        ADC_MCLK;
  logic [1:0]  ADC_SDAT = 2'b00;
  logic [15:0] ADC_DATA;
  logic        ADC_VALID;
  logic [1:0]  ADC_ERR;

  int n_checks = 0;
  int n_pass   = 0;

  always #41.667 OSCCLK = ~OSCCLK;

  urc_rover #(.NUM_ADCS(NUM_ADCS), .QUIET_CYC(2)) dut (
    .OSCCLK    (OSCCLK),
    .EXTRST    (EXTRST),
    .ADC_CS    (ADC_CS),
    .ADC_MCLK  (ADC_MCLK),
    .ADC_SDAT  (ADC_SDAT),
    .ADC_DATA  (ADC_DATA),
    .ADC_VALID (ADC_VALID),
    .ADC_ERR   (ADC_ERR)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  // AD7478 models: the frame is latched at CS fall and shifted on MCLK falls.
  logic [7:0]  model_val  [2] = '{8'hA5, 8'h5A};
  logic [3:0]  model_lead [2] = '{4'h0, 4'h0};
  logic [15:0] frame      [2];
  int          bit_idx = 0;

  always @(negedge ADC_CS or negedge ADC_MCLK) begin
    if (ADC_MCLK) begin
      bit_idx = 0;
      for (int ch = 0; ch < 2; ch++) frame[ch] = {model_lead[ch], model_val[ch], 4'h0};
    end else if (!ADC_CS && bit_idx < 16) begin
      for (int ch = 0; ch < 2; ch++) ADC_SDAT[ch] = frame[ch][15-bit_idx];
      bit_idx++;
    end
  end

  int rise_total = 0;
  always @(posedge ADC_MCLK) if (!ADC_CS) rise_total++;

  typedef struct {
    logic [15:0] data;
    logic [1:0]  err;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0, cs_fall_cyc = 0, rise_snap = 0, last_valid_cyc = 0;
  bit   have_last = 0;
  logic cs_prev = 1'b1;

  // Monitor sampled on the falling OSCCLK edge, away from DUT updates.
  always @(negedge OSCCLK) begin
    exp_t e;
    cyc++;
    if (EXTRST) begin
      sb.delete();
      have_last = 0;
    end else begin
      if (cs_prev && !ADC_CS) begin
        cs_fall_cyc = cyc;
        rise_snap   = rise_total;
        e.data = {model_val[1], model_val[0]};
        e.err  = {model_lead[1] != 4'h0, model_lead[0] != 4'h0};
        sb.push_back(e);
      end
      if (ADC_VALID) begin
        checkOutput("sb_pending", 32'(sb.size() > 0), 1);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          checkOutput("data", ADC_DATA, e.data);
          checkOutput("err", ADC_ERR, e.err);
          checkOutput("valid_latency", cyc - cs_fall_cyc, 34);
          checkOutput("mclk_rises", rise_total - rise_snap, 16);
          if (have_last) checkOutput("valid_period", cyc - last_valid_cyc, 36);
        end
        have_last      = 1;
        last_valid_cyc = cyc;
      end
    end
    cs_prev = ADC_CS;
  end

  task automatic waitValid();
    int n = 0;
    do begin
      @(negedge OSCCLK);
      n++;
    end while (!ADC_VALID && n < 100);
    checkOutput("valid_seen", ADC_VALID, 1);
  endtask

  // Waits for the current frame to publish, then loads the next frame's values.
  task automatic applyStimulus(input logic [7:0] v0, input logic [3:0] lead0, input logic [7:0] v1);
    waitValid();
    model_val[0]  = v0;
    model_lead[0] = lead0;
    model_val[1]  = v1;
    model_lead[1] = 4'h0;
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_cs"}, ADC_CS, 1);
    checkOutput({tag, "_mclk"}, ADC_MCLK, 1);
    checkOutput({tag, "_data"}, ADC_DATA, 0);
    checkOutput({tag, "_valid"}, ADC_VALID, 0);
    checkOutput({tag, "_err"}, ADC_ERR, 0);
  endtask

  initial begin
    int   edges;
    int   rises;
    logic mprev;

    #500;
    checkResetOutputs("reset_hold");
    #500;
    @(negedge OSCCLK);
    EXTRST = 1'b0;
    edges = 0;
    for (int n = 1; n <= 10 && edges == 0; n++) begin
      @(posedge OSCCLK);
      #1;
      if (!ADC_CS) edges = n;
    end
    checkOutput("cs_fall_edges", edges, 3);

    applyStimulus(8'h00, 4'h0, 8'h11);
    applyStimulus(8'hFF, 4'h0, 8'h22);
    applyStimulus(8'h3C, 4'h1, 8'h33);
    applyStimulus(8'h5A, 4'h0, 8'h44);
    checkOutput("corrupt_err", ADC_ERR, 2'b01);
    checkOutput("corrupt_data", ADC_DATA[7:0], 8'h3C);
    applyStimulus(8'h12, 4'h0, 8'hEF);
    checkOutput("clean_err", ADC_ERR, 2'b00);
    applyStimulus(8'h66, 4'h0, 8'h99);
    checkOutput("dual_data", ADC_DATA, 16'hEF12);

    edges = 0;
    for (int n = 0; n < 50 && edges == 0; n++) begin
      @(negedge OSCCLK);
      if (!ADC_CS) edges = 1;
    end
    checkOutput("abort_cs_fall", edges, 1);
    rises = 0;
    mprev = ADC_MCLK;
    for (int n = 0; n < 60 && rises < 10; n++) begin
      @(posedge OSCCLK);
      #1;
      if (ADC_MCLK && !mprev) rises++;
      mprev = ADC_MCLK;
    end
    checkOutput("abort_rises", rises, 10);
    checkOutput("abort_cs_low", ADC_CS, 0);
    EXTRST = 1'b1;
    #1;
    checkResetOutputs("abort");

    #200;
    model_val[0] = 8'h77;
    model_val[1] = 8'h88;
    @(negedge OSCCLK);
    EXTRST = 1'b0;
    waitValid();
    checkOutput("post_reset_data", ADC_DATA, 16'h8877);
    checkOutput("post_reset_err", ADC_ERR, 2'b00);

    repeat (4) @(negedge OSCCLK);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #100us;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] timeout");
  end

endmodule
